// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO carrying tdata/tkeep/tlast, with a cut-through mode and a
// store-and-forward mode that releases a packet only once it is fully buffered.
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int PACKET_MODE = 1,
    parameter int MAX_PKTS    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [$clog2(DEPTH):0]      level,
    output logic [$clog2(MAX_PKTS):0]   pkt_count,
    output logic                        rx_pkt_done,
    output logic                        tx_pkt_done,
    output logic                        o_dbg_tx_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PKTS) + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + KW + 1;
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [PW-1:0] PKT_MAX  = PW'(MAX_PKTS);
    localparam logic [PW-1:0] PKT_ONE  = PW'(1);

    // Handshake: a beat moves on a side only at an edge where its valid and
    // ready are both high; once m_axis_tvalid rises, the beat is held unchanged
    // until that handshake completes.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    tx_state_t r_state, w_state_next;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr, w_wr_next, w_rd_next;
    logic [AW:0]   w_level, w_level_next;
    logic [PW-1:0] r_pkt_count, w_pkt_next;
    logic          r_not_full, r_rx_done, r_tx_done;
    logic          w_push, w_pop, w_empty, w_pkt_sat, w_tx_valid;
    logic          w_pkt_inc, w_pkt_dec, w_overflow_next;
    logic [EW-1:0] w_head;
    logic          w_head_last;

    // Wrap-bit pointers: their difference is the occupancy, 0..DEPTH.
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_level == '0);
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_last = w_head[0];
    assign w_pkt_sat   = (r_pkt_count == PKT_MAX);

    // A saturated packet counter refuses only a beat that would close another packet.
    assign s_axis_tready = r_not_full && !(w_pkt_sat && s_axis_tlast);
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_tx_valid    = (PACKET_MODE != 0) ? ((r_state == ST_SEND) && !w_empty) : !w_empty;
    assign w_pop         = w_tx_valid && m_axis_tready;

    assign w_pkt_inc = w_push && s_axis_tlast;
    assign w_pkt_dec = w_pop && w_head_last;
    assign w_wr_next = w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    assign w_rd_next = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    assign w_level_next = w_wr_next - w_rd_next;

    always_comb begin
        w_pkt_next = r_pkt_count;
        if (w_pkt_inc && !w_pkt_dec) begin
            w_pkt_next = r_pkt_count + PKT_ONE;
        end else if (!w_pkt_inc && w_pkt_dec) begin
            w_pkt_next = r_pkt_count - PKT_ONE;
        end
    end

    // A full buffer with no complete packet can only make progress by streaming.
    assign w_overflow_next = (w_level_next == FULL_LVL) && (w_pkt_next == '0);

    // Decisions use next-edge counts so a packet is offered the cycle after its tlast lands.
    always_comb begin
        w_state_next = r_state;
        if (PACKET_MODE != 0) begin
            case (r_state)
                ST_IDLE: begin
                    if ((w_pkt_next != '0) || w_overflow_next) begin
                        w_state_next = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_pkt_dec && (w_pkt_next == '0) && !w_overflow_next) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_count <= '0;
            r_state     <= ST_IDLE;
            r_not_full  <= 1'b0;
            r_rx_done   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_pkt_count <= w_pkt_next;
            r_state     <= w_state_next;
            r_not_full  <= (w_level_next != FULL_LVL);
            r_rx_done   <= w_pkt_inc;
            r_tx_done   <= w_pkt_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        end
    end

    // Payload is zeroed whenever no beat is offered, which also covers reset.
    assign m_axis_tvalid  = w_tx_valid;
    assign m_axis_tdata   = w_tx_valid ? w_head[EW-1 -: DATA_WIDTH] : '0;
    assign m_axis_tkeep   = w_tx_valid ? w_head[KW:1] : '0;
    assign m_axis_tlast   = w_tx_valid && w_head_last;
    assign level          = w_level;
    assign pkt_count      = r_pkt_count;
    assign rx_pkt_done    = r_rx_done;
    assign tx_pkt_done    = r_tx_done;
    assign o_dbg_tx_state = r_state;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: three instances (store-and-forward depth 64,
// cut-through depth 8, store-and-forward depth 8) checked through one scoreboard.
module tb_axis_packet_fifo;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int BW = DW + KW + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]         s_valid, s_last, s_ready, m_valid, m_last, m_ready;
    logic [2:0]         rx_done, tx_done, dbg;
    logic [2:0][DW-1:0] s_data, m_data;
    logic [2:0][KW-1:0] s_keep, m_keep;
    logic [2:0][4:0]    pkt;
    logic [6:0]         lvl_a;
    logic [3:0]         lvl_b, lvl_c;

    axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(64), .PACKET_MODE(1), .MAX_PKTS(16)) u_sf (
        .clk(clk), .reset(rst),
        .s_axis_tvalid(s_valid[0]), .s_axis_tdata(s_data[0]), .s_axis_tkeep(s_keep[0]),
        .s_axis_tlast(s_last[0]), .s_axis_tready(s_ready[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tdata(m_data[0]), .m_axis_tkeep(m_keep[0]),
        .m_axis_tlast(m_last[0]), .m_axis_tready(m_ready[0]),
        .level(lvl_a), .pkt_count(pkt[0]), .rx_pkt_done(rx_done[0]),
        .tx_pkt_done(tx_done[0]), .o_dbg_tx_state(dbg[0])
    );

    axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .PACKET_MODE(0), .MAX_PKTS(16)) u_ct (
        .clk(clk), .reset(rst),
        .s_axis_tvalid(s_valid[1]), .s_axis_tdata(s_data[1]), .s_axis_tkeep(s_keep[1]),
        .s_axis_tlast(s_last[1]), .s_axis_tready(s_ready[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tdata(m_data[1]), .m_axis_tkeep(m_keep[1]),
        .m_axis_tlast(m_last[1]), .m_axis_tready(m_ready[1]),
        .level(lvl_b), .pkt_count(pkt[1]), .rx_pkt_done(rx_done[1]),
        .tx_pkt_done(tx_done[1]), .o_dbg_tx_state(dbg[1])
    );

    axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .PACKET_MODE(1), .MAX_PKTS(16)) u_of (
        .clk(clk), .reset(rst),
        .s_axis_tvalid(s_valid[2]), .s_axis_tdata(s_data[2]), .s_axis_tkeep(s_keep[2]),
        .s_axis_tlast(s_last[2]), .s_axis_tready(s_ready[2]),
        .m_axis_tvalid(m_valid[2]), .m_axis_tdata(m_data[2]), .m_axis_tkeep(m_keep[2]),
        .m_axis_tlast(m_last[2]), .m_axis_tready(m_ready[2]),
        .level(lvl_c), .pkt_count(pkt[2]), .rx_pkt_done(rx_done[2]),
        .tx_pkt_done(tx_done[2]), .o_dbg_tx_state(dbg[2])
    );

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    logic [BW-1:0] exp_q[$];
    bit            prev_hold = 1'b0;
    logic [BW-1:0] prev_beat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int get_level(input int i);
        if (i == 0) return int'(lvl_a);
        if (i == 1) return int'(lvl_b);
        return int'(lvl_c);
    endfunction

    // Monitor: pops the expected queue on every output handshake of the selected instance
    always @(negedge clk) begin
        logic [BW-1:0] cur;
        logic [BW-1:0] e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            cur = {m_data[sel], m_keep[sel], m_last[sel]};
            if (prev_hold) begin
                chk("hold_valid", 64'(m_valid[sel]), 64'd1);
                chk("hold_beat", 64'(cur), 64'(prev_beat));
            end
            if (m_valid[sel] && m_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(cur), 64'(e));
                end
            end
            prev_hold = m_valid[sel] && !m_ready[sel];
            prev_beat = cur;
            rx_cnt += int'(rx_done[sel]);
            tx_cnt += int'(tx_done[sel]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int i, input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input bit quiet);
        bit done;
        done = 1'b0;
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        s_keep[i]  = k;
        s_last[i]  = l;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (quiet) chk("quiet_valid", 64'(m_valid[i]), 64'd0);
            if (s_ready[i]) begin
                exp_q.push_back({d, k, l});
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: inst %0d got no tready expected tready", i);
        end
        tick();
    endtask

    task automatic send_pkt(input int i, input int len, input int base, input bit with_last,
                            input bit quiet);
        for (int b = 0; b < len; b++) begin
            send_beat(i, DW'(base + b), 4'hF, with_last && (b == len - 1), quiet);
        end
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
    endtask

    task automatic wait_drain(input int i, input string nm);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid[i]) ok = 1'b1;
        end
        chk({nm, "_drained"}, 64'(ok), 64'd1);
        tick();
    endtask

    task automatic test_sf_basic();
        sel = 0;
        m_ready[0] = 1'b1;
        rx_cnt = 0;
        tx_cnt = 0;
        send_pkt(0, 50, 1, 1'b1, 1'b1);
        @(negedge clk);
        chk("sf_valid_after_last", 64'(m_valid[0]), 64'd1);
        wait_drain(0, "sf");
        chk("sf_level", 64'(get_level(0)), 64'd0);
        chk("sf_rx_pulses", 64'(rx_cnt), 64'd1);
        chk("sf_tx_pulses", 64'(tx_cnt), 64'd1);
        chk("sf_state_idle", 64'(dbg[0]), 64'd0);
    endtask

    task automatic test_backpressure();
        m_ready[0] = 1'b0;
        rx_cnt = 0;
        tx_cnt = 0;
        send_pkt(0, 50, 1, 1'b1, 1'b1);
        repeat (5) tick();
        m_ready[0] = 1'b1;
        tick();
        m_ready[0] = 1'b0;
        repeat (15) tick();
        m_ready[0] = 1'b1;
        wait_drain(0, "bp");
        chk("bp_level", 64'(get_level(0)), 64'd0);
        chk("bp_rx_pulses", 64'(rx_cnt), 64'd1);
        chk("bp_tx_pulses", 64'(tx_cnt), 64'd1);
    endtask

    task automatic test_multi();
        int hist[$];
        int last_seen;
        int gaps;
        bit fin;
        m_ready[0] = 1'b0;
        send_pkt(0, 1, 100, 1'b1, 1'b0);
        send_pkt(0, 7, 110, 1'b1, 1'b0);
        send_pkt(0, 20, 120, 1'b1, 1'b0);
        @(negedge clk);
        chk("mp_pkt_count", 64'(pkt[0]), 64'd3);
        chk("mp_level", 64'(get_level(0)), 64'd28);
        tick();
        m_ready[0] = 1'b1;
        last_seen = -1;
        gaps = 0;
        fin = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            @(negedge clk);
            if (int'(pkt[0]) != last_seen) begin
                last_seen = int'(pkt[0]);
                hist.push_back(last_seen);
            end
            if (get_level(0) == 0) fin = 1'b1;
            else if (!m_valid[0]) gaps++;
        end
        chk("mp_finished", 64'(fin), 64'd1);
        chk("mp_gaps", 64'(gaps), 64'd0);
        chk("mp_steps", 64'(hist.size()), 64'd4);
        for (int k = 0; k < hist.size() && k < 4; k++) begin
            chk("mp_step_value", 64'(hist[k]), 64'(3 - k));
        end
        wait_drain(0, "mp");
    endtask

    task automatic test_reset_mid();
        m_ready[0] = 1'b0;
        send_pkt(0, 3, 300, 1'b1, 1'b0);
        send_pkt(0, 9, 400, 1'b0, 1'b0);
        s_valid[0] = 1'b1;
        s_data[0]  = 32'd409;
        s_last[0]  = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rm_valid", 64'(m_valid[0]), 64'd0);
        chk("rm_level", 64'(get_level(0)), 64'd0);
        chk("rm_pkt", 64'(pkt[0]), 64'd0);
        chk("rm_tready", 64'(s_ready[0]), 64'd0);
        s_valid[0] = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;
        tick();
        chk("rm_tready_back", 64'(s_ready[0]), 64'd1);
        m_ready[0] = 1'b1;
        rx_cnt = 0;
        tx_cnt = 0;
        send_pkt(0, 5, 500, 1'b1, 1'b0);
        wait_drain(0, "rm");
        chk("rm_level_end", 64'(get_level(0)), 64'd0);
        chk("rm_rx_pulses", 64'(rx_cnt), 64'd1);
        chk("rm_tx_pulses", 64'(tx_cnt), 64'd1);
    endtask

    task automatic test_cut_through();
        sel = 1;
        m_ready[1] = 1'b1;
        send_beat(1, 32'hA5A5_A5A5, 4'b0011, 1'b1, 1'b1);
        s_valid[1] = 1'b0;
        s_last[1]  = 1'b0;
        @(negedge clk);
        chk("ct_valid", 64'(m_valid[1]), 64'd1);
        chk("ct_data", 64'(m_data[1]), 64'hA5A5_A5A5);
        chk("ct_keep", 64'(m_keep[1]), 64'h3);
        chk("ct_last", 64'(m_last[1]), 64'd1);
        wait_drain(1, "ct");
    endtask

    task automatic test_full();
        int lv;
        sel = 2;
        m_ready[2] = 1'b0;
        send_pkt(2, 8, 200, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_tready", 64'(s_ready[2]), 64'd0);
        chk("full_level", 64'(get_level(2)), 64'd8);
        chk("full_release_valid", 64'(m_valid[2]), 64'd1);
        chk("full_state_send", 64'(dbg[2]), 64'd1);
        tick();
        m_ready[2] = 1'b1;
        for (int b = 0; b < 16; b++) begin
            send_beat(2, DW'(208 + b), 4'hF, 1'b0, 1'b0);
            lv = get_level(2);
            chk("full_level_band", 64'(lv >= 7 && lv <= 8), 64'd1);
        end
        s_valid[2] = 1'b0;
        wait_drain(2, "full");
        chk("full_level_end", 64'(get_level(2)), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        s_keep  = '0;
        m_ready = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_tready", 64'(s_ready[i]), 64'd0);
            chk("rst_tvalid", 64'(m_valid[i]), 64'd0);
            chk("rst_payload", 64'({m_data[i], m_keep[i], m_last[i]}), 64'd0);
            chk("rst_pulses", 64'({rx_done[i], tx_done[i]}), 64'd0);
            chk("rst_level", 64'(get_level(i)), 64'd0);
            chk("rst_pkt", 64'(pkt[i]), 64'd0);
        end
        #2;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("tready_after_rst", 64'(s_ready[i]), 64'd1);
        end

        test_sf_basic();
        test_backpressure();
        test_multi();
        test_reset_mid();
        test_cut_through();
        test_full();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
